// File: rtl/mem_arbiter_if.sv
// Bundle of requester ports (CPU and host), byte-RAM port and busy flag
// shared between mem_arbiter (slave) and the surrounding system (master).
interface mem_arbiter_if #(
    parameter int AW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic          cpu_wide;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_wdata;
    logic          cpu_ack;
    logic [15:0]   cpu_rdata;

    logic          host_req;
    logic          host_we;
    logic          host_wide;
    logic [AW-1:0] host_addr;
    logic [15:0]   host_wdata;
    logic          host_ack;
    logic [15:0]   host_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_wide, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_wide, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_wide, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_wide, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/host arbiter sequencing byte and little-endian word
// accesses onto a single-port synchronous byte RAM. All outputs registered.
module mem_arbiter #(
    parameter int AW = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    state_t        r_state, w_state_next;
    logic          r_owner, w_owner_next;
    logic          r_last, w_last_next;
    logic          r_we, w_we_next;
    logic          r_wide, w_wide_next;
    logic [7:0]    r_wdata_hi, w_wdata_hi_next;
    logic [7:0]    r_lo_buf, w_lo_buf_next;
    logic          r_cpu_ack, w_cpu_ack_next;
    logic          r_host_ack, w_host_ack_next;
    logic [15:0]   r_cpu_rdata, w_cpu_rdata_next;
    logic [15:0]   r_host_rdata, w_host_rdata_next;
    logic          r_mem_en, w_mem_en_next;
    logic          r_mem_we, w_mem_we_next;
    logic [AW-1:0] r_mem_addr, w_mem_addr_next;
    logic [7:0]    r_mem_wdata, w_mem_wdata_next;
    logic          r_busy, w_busy_next;

    logic          w_grant_host;
    logic          w_sel_we;
    logic          w_sel_wide;
    logic [AW-1:0] w_sel_addr;
    logic [15:0]   w_sel_wdata;
    logic [15:0]   w_rd_word;

    // On a tie the port that did not win last time gets the grant.
    assign w_grant_host = bus.host_req && (!bus.cpu_req || (r_last == PORT_CPU));
    assign w_sel_we     = w_grant_host ? bus.host_we    : bus.cpu_we;
    assign w_sel_wide   = w_grant_host ? bus.host_wide  : bus.cpu_wide;
    assign w_sel_addr   = w_grant_host ? bus.host_addr  : bus.cpu_addr;
    assign w_sel_wdata  = w_grant_host ? bus.host_wdata : bus.cpu_wdata;
    assign w_rd_word    = r_wide ? {bus.mem_rdata, r_lo_buf} : {8'h00, bus.mem_rdata};

    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_next       = r_last;
        w_we_next         = r_we;
        w_wide_next       = r_wide;
        w_wdata_hi_next   = r_wdata_hi;
        w_lo_buf_next     = r_lo_buf;
        w_cpu_ack_next    = 1'b0;
        w_host_ack_next   = 1'b0;
        w_cpu_rdata_next  = r_cpu_rdata;
        w_host_rdata_next = r_host_rdata;
        w_mem_en_next     = r_mem_en;
        w_mem_we_next     = r_mem_we;
        w_mem_addr_next   = r_mem_addr;
        w_mem_wdata_next  = r_mem_wdata;

        unique case (r_state)
            IDLE: begin
                // Blocking the grant while an ack is out yields the dead cycle.
                if ((bus.cpu_req || bus.host_req) && !r_cpu_ack && !r_host_ack) begin
                    w_owner_next     = w_grant_host;
                    w_last_next      = w_grant_host;
                    w_we_next        = w_sel_we;
                    w_wide_next      = w_sel_wide;
                    w_wdata_hi_next  = w_sel_wdata[15:8];
                    w_mem_en_next    = 1'b1;
                    w_mem_we_next    = w_sel_we;
                    w_mem_addr_next  = w_sel_addr;
                    w_mem_wdata_next = w_sel_wdata[7:0];
                    w_state_next     = ACC0;
                end
            end
            ACC0: begin
                if (r_wide) begin
                    w_mem_addr_next  = r_mem_addr + AW'(1);
                    w_mem_wdata_next = r_wdata_hi;
                    w_state_next     = ACC1;
                end else begin
                    w_mem_en_next = 1'b0;
                    w_mem_we_next = 1'b0;
                    w_state_next  = RESP;
                end
            end
            ACC1: begin
                w_lo_buf_next = bus.mem_rdata;
                w_mem_en_next = 1'b0;
                w_mem_we_next = 1'b0;
                w_state_next  = RESP;
            end
            RESP: begin
                if (r_owner == PORT_HOST) begin
                    w_host_ack_next = 1'b1;
                    if (!r_we) w_host_rdata_next = w_rd_word;
                end else begin
                    w_cpu_ack_next = 1'b1;
                    if (!r_we) w_cpu_rdata_next = w_rd_word;
                end
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_owner      <= PORT_CPU;
            r_last       <= PORT_HOST;
            r_we         <= 1'b0;
            r_wide       <= 1'b0;
            r_wdata_hi   <= 8'h00;
            r_lo_buf     <= 8'h00;
            r_cpu_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_cpu_rdata  <= 16'h0000;
            r_host_rdata <= 16'h0000;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'h00;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last       <= w_last_next;
            r_we         <= w_we_next;
            r_wide       <= w_wide_next;
            r_wdata_hi   <= w_wdata_hi_next;
            r_lo_buf     <= w_lo_buf_next;
            r_cpu_ack    <= w_cpu_ack_next;
            r_host_ack   <= w_host_ack_next;
            r_cpu_rdata  <= w_cpu_rdata_next;
            r_host_rdata <= w_host_rdata_next;
            r_mem_en     <= w_mem_en_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_busy       <= w_busy_next;
        end
    end

    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.host_ack   = r_host_ack;
    assign bus.host_rdata = r_host_rdata;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model plus step-by-step checks
// of latency, data, wrap, fairness, reset abandonment and re-request.
module tb_mem_arbiter;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if #(.AW(16)) bus ();

    mem_arbiter #(.AW(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // Synchronous byte RAM with a preload port and an access log.
    logic [7:0]  mem [0:65535];
    logic [7:0]  ram_rdata = 8'h00;
    logic        pl_en     = 1'b0;
    logic [15:0] pl_addr   = 16'h0000;
    logic [7:0]  pl_data   = 8'h00;
    logic [24:0] acc_log [$];
    int          log_rd    = 0;

    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            ram_rdata <= mem[bus.mem_addr];
            acc_log.push_back({bus.mem_we, bus.mem_addr, bus.mem_wdata});
        end
    end

    assign bus.mem_rdata = ram_rdata;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic log_mark();
        log_rd = acc_log.size();
    endtask

    task automatic next_log(output logic [24:0] e);
        if (log_rd < acc_log.size()) begin
            e = acc_log[log_rd];
            log_rd++;
        end else begin
            e = '1;
        end
    endtask

    task automatic set_cpu(input logic we, input logic wide, input logic [15:0] a, input logic [15:0] d);
        bus.cpu_we    = we;
        bus.cpu_wide  = wide;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_req   = 1'b1;
    endtask

    task automatic set_host(input logic we, input logic wide, input logic [15:0] a, input logic [15:0] d);
        bus.host_we    = we;
        bus.host_wide  = wide;
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_req   = 1'b1;
    endtask

    task automatic wait_grant(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called in the grant sample; returns cycles to the owner's ack.
    task automatic run_until_ack(input logic host, output int lat, output int en_cnt, output logic other);
        lat    = 0;
        en_cnt = 1;
        other  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat++;
            if (host ? bus.host_ack : bus.cpu_ack) break;
            if (bus.mem_en) en_cnt++;
            if (host ? bus.cpu_ack : bus.host_ack) other = 1'b1;
        end
    endtask

    initial begin
        logic        ok;
        logic        other;
        logic        prev;
        logic        both;
        int          lat;
        int          en_cnt;
        int          nack;
        int          bad;
        int          ack_cyc  [4];
        logic        ack_host [4];
        logic [15:0] ack_data [4];
        logic [24:0] e;

        bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_wide = 1'b0;
        bus.cpu_addr = 16'h0; bus.cpu_wdata = 16'h0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_wide = 1'b0;
        bus.host_addr = 16'h0; bus.host_wdata = 16'h0;

        // Reset state
        repeat (3) tick();
        check("rst_cpu_ack",    bus.cpu_ack,    0);
        check("rst_host_ack",   bus.host_ack,   0);
        check("rst_mem_en",     bus.mem_en,     0);
        check("rst_busy",       bus.busy,       0);
        check("rst_cpu_rdata",  bus.cpu_rdata,  0);
        check("rst_host_rdata", bus.host_rdata, 0);
        check("rst_mem_addr",   bus.mem_addr,   0);
        reset_n = 1'b1;

        preload(16'h0040, 8'hA5);
        preload(16'h0010, 8'h34);
        preload(16'h0011, 8'h12);
        preload(16'h0100, 8'h00);
        preload(16'h0101, 8'h77);
        check("idle_busy", bus.busy, 0);

        // CPU byte read
        log_mark();
        set_cpu(1'b0, 1'b0, 16'h0040, 16'h0000);
        wait_grant(ok);
        check("t1_grant", ok, 1);
        check("t1_addr",  bus.mem_addr, 16'h0040);
        check("t1_we",    bus.mem_we, 0);
        check("t1_busy",  bus.busy, 1);
        run_until_ack(1'b0, lat, en_cnt, other);
        bus.cpu_req = 1'b0;
        check("t1_lat",   lat, 2);
        check("t1_en",    en_cnt, 1);
        check("t1_rdata", bus.cpu_rdata, 16'h00A5);
        check("t1_log_n", acc_log.size() - log_rd, 1);
        tick();
        check("t1_ack_single", bus.cpu_ack, 0);

        // Host word read
        log_mark();
        set_host(1'b0, 1'b1, 16'h0010, 16'h0000);
        wait_grant(ok);
        check("t2_grant", ok, 1);
        run_until_ack(1'b1, lat, en_cnt, other);
        bus.host_req = 1'b0;
        check("t2_lat",   lat, 3);
        check("t2_en",    en_cnt, 2);
        check("t2_rdata", bus.host_rdata, 16'h1234);
        check("t2_cpu_ack_quiet", other, 0);
        next_log(e);
        check("t2_addr0", e[24:8], 32'h0000_0010);
        next_log(e);
        check("t2_addr1", e[24:8], 32'h0000_0011);
        tick();
        check("t2_ack_single", bus.host_ack, 0);

        // CPU word write wrapping past the top of memory
        log_mark();
        set_cpu(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
        wait_grant(ok);
        check("t3_grant", ok, 1);
        run_until_ack(1'b0, lat, en_cnt, other);
        bus.cpu_req = 1'b0;
        check("t3_lat",    lat, 3);
        check("t3_en",     en_cnt, 2);
        check("t3_rdata_hold", bus.cpu_rdata, 16'h00A5);
        next_log(e);
        check("t3_wr_lo", e, 32'h01FF_FFEF);
        next_log(e);
        check("t3_wr_hi", e, 32'h0100_00BE);
        check("t3_mem_ffff", mem[16'hFFFF], 8'hEF);
        check("t3_mem_0000", mem[16'h0000], 8'hBE);
        tick();

        // Reset while the high byte of a word write is pending
        set_cpu(1'b1, 1'b1, 16'h0100, 16'hC35A);
        wait_grant(ok);
        check("t4_grant", ok, 1);
        tick();
        check("t4_acc1_en",   bus.mem_en, 1);
        check("t4_acc1_addr", bus.mem_addr, 16'h0101);
        reset_n = 1'b0;
        #1;
        check("t4_rst_en",    bus.mem_en, 0);
        check("t4_rst_busy",  bus.busy, 0);
        check("t4_rst_rdata", bus.cpu_rdata, 0);
        bus.cpu_req = 1'b0;
        other = 1'b0;
        repeat (3) begin
            tick();
            if (bus.cpu_ack || bus.host_ack) other = 1'b1;
        end
        check("t4_no_ack",  other, 0);
        check("t4_mem_lo",  mem[16'h0100], 8'h5A);
        check("t4_mem_hi",  mem[16'h0101], 8'h77);
        reset_n = 1'b1;
        tick();

        // Both ports requesting: CPU first after reset, then alternating
        set_cpu(1'b0, 1'b0, 16'h0010, 16'h0000);
        set_host(1'b0, 1'b0, 16'h0040, 16'h0000);
        nack = 0; bad = 0; prev = 1'b0; both = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ack_cyc[i] = 0; ack_host[i] = 1'b0; ack_data[i] = 16'h0;
        end
        for (int cyc = 0; cyc < 60 && nack < 4; cyc++) begin
            tick();
            if (prev && (bus.cpu_ack || bus.host_ack || bus.mem_en)) bad++;
            if (bus.cpu_ack && bus.host_ack) both = 1'b1;
            prev = bus.cpu_ack || bus.host_ack;
            if (prev) begin
                ack_cyc[nack]  = cyc;
                ack_host[nack] = bus.host_ack;
                ack_data[nack] = bus.host_ack ? bus.host_rdata : bus.cpu_rdata;
                nack++;
            end
        end
        bus.cpu_req  = 1'b0;
        bus.host_req = 1'b0;
        tick();
        check("t5_nack", nack, 4);
        check("t5_both", both, 0);
        check("t5_dead", bad, 0);
        check("t5_last_dead", {bus.cpu_ack, bus.host_ack, bus.mem_en}, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_port%0d", i), ack_host[i], i % 2);
            check($sformatf("t5_data%0d", i), ack_data[i], (i % 2) ? 32'h00A5 : 32'h0034);
        end
        for (int i = 1; i < 4; i++)
            check($sformatf("t5_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);

        // Host keeps req through its ack: re-granted after the dead cycle
        set_host(1'b1, 1'b0, 16'h0020, 16'h0033);
        wait_grant(ok);
        check("t6_grant", ok, 1);
        run_until_ack(1'b1, lat, en_cnt, other);
        check("t6_lat", lat, 2);
        check("t6_rdata_hold", bus.host_rdata, 16'h00A5);
        tick();
        check("t6_dead_en", bus.mem_en, 0);
        tick();
        check("t6_regrant_en",    bus.mem_en, 1);
        check("t6_regrant_addr",  bus.mem_addr, 16'h0020);
        check("t6_regrant_we",    bus.mem_we, 1);
        check("t6_regrant_wdata", bus.mem_wdata, 8'h33);
        bus.host_req   = 1'b0;
        bus.host_addr  = 16'h0099;
        bus.host_wdata = 16'hFFFF;
        run_until_ack(1'b1, lat, en_cnt, other);
        check("t6_lat2",   lat, 2);
        check("t6_cpu_quiet", other, 0);
        check("t6_mem",    mem[16'h0020], 8'h33);
        tick();
        check("t6_idle", {bus.busy, bus.host_ack}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
